// File: rtl/ex_muldiv_unit_pkg.sv
// Shared execute-stage definitions: ALU op encodings, RV32M funct3 constants
// and the multiply/divide FSM state type.
package muldiv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // funct3[2] separates the divide family from the multiply family.
  function automatic logic f3_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage <-> multiply/divide unit connection.
// Handshake: start is sampled only in IDLE; stall is high while the op is in
// flight; result is valid exactly in the single cycle result_valid is high.
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
) ();
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            stall;
  logic [XLEN-1:0] result;
  logic            result_valid;

  modport master (
    output start, flush, funct3, rs1_data, rs2_data,
    input  stall, result, result_valid
  );

  modport slave (
    input  start, flush, funct3, rs1_data, rs2_data,
    output stall, result, result_valid
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M unit: one radix-2 step per cycle on sign-stripped magnitudes,
// with divide-by-zero and signed overflow resolved without iterating.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  ex_muldiv_unit_if.slave md_bus,
  output md_state_t       o_dbg_state
);

  md_state_t         r_state;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opnd;
  logic [5:0]        r_cnt;
  logic [2:0]        r_funct3;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [XLEN-1:0]   r_result;
  logic              r_result_valid;

  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_div_zero;
  logic              w_ovf;
  logic [XLEN-1:0]   w_bypass_res;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_rem_ext;
  logic              w_div_ge;
  logic [XLEN-1:0]   w_div_sub;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_step;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_final;

  // Operand decode at the latch cycle.
  always_comb begin
    w_a_neg = 1'b0;
    w_b_neg = 1'b0;
    case (md_bus.funct3)
      F3_MULH, F3_DIV, F3_REM: begin
        w_a_neg = md_bus.rs1_data[XLEN-1];
        w_b_neg = md_bus.rs2_data[XLEN-1];
      end
      F3_MULHSU: w_a_neg = md_bus.rs1_data[XLEN-1];
      default: ;
    endcase
    w_a_mag    = w_a_neg ? -md_bus.rs1_data : md_bus.rs1_data;
    w_b_mag    = w_b_neg ? -md_bus.rs2_data : md_bus.rs2_data;
    w_div_zero = f3_is_div(md_bus.funct3) && (md_bus.rs2_data == '0);
    w_ovf      = ((md_bus.funct3 == F3_DIV) || (md_bus.funct3 == F3_REM)) &&
                 (md_bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (md_bus.rs2_data == '1);
    if (w_div_zero)
      w_bypass_res = md_bus.funct3[1] ? md_bus.rs1_data : '1;
    else
      w_bypass_res = md_bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // Shift-add: low half holds the multiplier, high half accumulates.
  // Restoring divide: high half is the partial remainder, low half the quotient.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opnd};
    w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[XLEN-1:1]}
                          : {1'b0, r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1:1]};
    w_rem_ext  = r_acc[2*XLEN-1:XLEN-1];
    w_div_ge   = (w_rem_ext >= {1'b0, r_opnd});
    w_div_sub  = w_rem_ext[XLEN-1:0] - r_opnd;
    w_div_next = w_div_ge ? {w_div_sub, r_acc[XLEN-2:0], 1'b1}
                          : {w_rem_ext[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
    w_step     = f3_is_div(r_funct3) ? w_div_next : w_mul_next;
    w_prod     = r_neg_q ? -w_step : w_step;
    w_quo      = r_neg_q ? -w_step[XLEN-1:0] : w_step[XLEN-1:0];
    w_rem      = r_neg_r ? -w_step[2*XLEN-1:XLEN] : w_step[2*XLEN-1:XLEN];
  end

  always_comb begin
    w_final = w_prod[XLEN-1:0];
    case (r_funct3)
      F3_MUL:                       w_final = w_prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              w_final = w_quo;
      default:                      w_final = w_rem;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_acc          <= '0;
      r_opnd         <= '0;
      r_cnt          <= '0;
      r_funct3       <= '0;
      r_neg_q        <= 1'b0;
      r_neg_r        <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      if (md_bus.flush) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (md_bus.start) begin
              r_funct3 <= md_bus.funct3;
              r_neg_q  <= w_a_neg ^ w_b_neg;
              r_neg_r  <= w_a_neg;
              r_acc    <= {{XLEN{1'b0}}, w_a_mag};
              r_opnd   <= w_b_mag;
              r_cnt    <= '0;
              if (w_div_zero || w_ovf) begin
                r_result       <= w_bypass_res;
                r_result_valid <= 1'b1;
                r_state        <= DONE;
              end else begin
                r_state <= CALC;
              end
            end
          end
          CALC: begin
            r_acc <= w_step;
            r_cnt <= r_cnt + 6'd1;
            if (r_cnt == 6'(XLEN-1)) begin
              r_result       <= w_final;
              r_result_valid <= 1'b1;
              r_state        <= DONE;
            end
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // A start arriving while rst is held must not freeze the pipeline.
  assign md_bus.stall        = !rst && (((r_state == IDLE) && md_bus.start && !md_bus.flush) ||
                                        (r_state == CALC));
  assign md_bus.result       = r_result;
  assign md_bus.result_valid = r_result_valid;
  assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: driver tasks push expected results,
// an independent monitor pops and compares on every result_valid pulse.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  logic      clk;
  logic      rst;
  md_state_t dbg_state;

  int checks;
  int errors;
  logic [31:0] exp_q[$];

  ex_muldiv_unit_if #(.XLEN(32)) bus_if ();

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .md_bus     (bus_if),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp_v);
    end
  endtask

  // monitor / scoreboard
  initial begin
    logic [31:0] exp_v;
    forever begin
      @(negedge clk);
      #1;
      if (bus_if.result_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid actual=%h required=no_pulse", bus_if.result);
        end else begin
          exp_v = exp_q.pop_front();
          check("result", bus_if.result, exp_v);
        end
      end
    end
  end

  // Issues one op and holds start high like a stalled ID/EX register would.
  task automatic do_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_stalls);
    int cyc;
    int stalls;
    int vcyc;
    @(negedge clk);
    bus_if.start    = 1'b1;
    bus_if.funct3   = f3;
    bus_if.rs1_data = a;
    bus_if.rs2_data = b;
    exp_q.push_back(exp_res);
    cyc    = 0;
    stalls = 0;
    vcyc   = 0;
    #1;
    check({nm, "_idle_at_start"}, 32'(dbg_state), 32'(IDLE));
    while (vcyc == 0 && cyc < 100) begin
      cyc++;
      if (bus_if.result_valid === 1'b1) begin
        vcyc = cyc;
        check({nm, "_stall_in_done"}, 32'(bus_if.stall), 32'd0);
      end else if (bus_if.stall === 1'b1) begin
        stalls++;
      end
      if (vcyc == 0) begin
        @(negedge clk);
        bus_if.rs1_data = $urandom;
        bus_if.rs2_data = $urandom;
        #1;
      end
    end
    check({nm, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    check({nm, "_valid_cycle"}, 32'(vcyc), 32'(exp_stalls + 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus_if.start = 1'b0;
      bus_if.flush = 1'b0;
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    bus_if.start    = 1'b1;
    bus_if.flush    = 1'b0;
    bus_if.funct3   = F3_MUL;
    bus_if.rs1_data = 32'd3;
    bus_if.rs2_data = 32'd4;
    #12;
    check("reset_stall", 32'(bus_if.stall), 32'd0);
    check("reset_result", bus_if.result, 32'd0);
    check("reset_valid", 32'(bus_if.result_valid), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    bus_if.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    do_op("mul_7_m3",     F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    idle(1);
    do_op("mulh_min",     F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
    idle(2);
    do_op("mulhu_max",    F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    idle(1);
    do_op("mulhsu_m1_2",  F3_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
    idle(1);
    do_op("mul_lo",       F3_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 33);
    idle(1);
    do_op("div_m7_2",     F3_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    idle(1);
    do_op("rem_m7_2",     F3_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    idle(1);
    do_op("div_7_m2",     F3_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    idle(1);
    do_op("rem_7_m2",     F3_REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, 33);
    idle(1);
    do_op("divu_max_1",   F3_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33);
    idle(1);
    do_op("remu_100_7",   F3_REMU,   32'd100,      32'd7,        32'd2,        33);
    idle(1);
    do_op("divu_by_zero", F3_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1);
    idle(1);
    do_op("rem_by_zero",  F3_REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1);
    idle(1);
    do_op("div_ovf",      F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    idle(1);
    do_op("rem_ovf",      F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    idle(2);

    // flush during the tenth CALC cycle
    @(negedge clk);
    bus_if.start    = 1'b1;
    bus_if.funct3   = F3_MUL;
    bus_if.rs1_data = 32'd9;
    bus_if.rs2_data = 32'd9;
    repeat (10) @(negedge clk);
    bus_if.flush = 1'b1;
    #1;
    check("flush_in_calc", 32'(dbg_state), 32'(CALC));
    @(negedge clk);
    bus_if.flush = 1'b0;
    bus_if.start = 1'b0;
    #1;
    check("flush_state", 32'(dbg_state), 32'(IDLE));
    check("flush_stall", 32'(bus_if.stall), 32'd0);
    check("flush_valid", 32'(bus_if.result_valid), 32'd0);
    idle(40);
    do_op("divu_after_flush", F3_DIVU, 32'd100, 32'd7, 32'd14, 33);
    idle(2);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    bus_if.start    = 1'b1;
    bus_if.funct3   = F3_DIVU;
    bus_if.rs1_data = 32'd1000;
    bus_if.rs2_data = 32'd3;
    repeat (15) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_stall", 32'(bus_if.stall), 32'd0);
    check("midrst_result", bus_if.result, 32'd0);
    check("midrst_valid", 32'(bus_if.result_valid), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    bus_if.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(40);

    // back to back: second start in the IDLE cycle right after DONE
    do_op("b2b_mul",  F3_MUL,  32'd6,   32'd7, 32'd42, 33);
    do_op("b2b_divu", F3_DIVU, 32'd100, 32'd7, 32'd14, 33);
    idle(5);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/result width; only 32 is supported.
REQ-002 SHALL have clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have start  input  1  request from the EX stage: the current ID/EX instruction is an RV32M op.
REQ-005 SHALL have flush  input  1  abort from the hazard unit (branch taken / pipeline flush).
REQ-006 SHALL have funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have rs1_data  input  32  forwarded operand A (dividend / multiplicand).
REQ-008 SHALL have rs2_data  input  32  forwarded operand B (divisor / multiplier).
REQ-009 SHALL have stall  output  1  combinational; when high, the hazard unit holds the PC, IF/ID and ID/EX.
REQ-010 SHALL have result  output  32  op result; valid only while result_valid is high.
REQ-011 SHALL have result_valid  output  1  one-cycle pulse; EX/MEM captures result in this cycle.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 IDLE: start=1 and flush=0 SHALL latch funct3, |rs1|, |rs2|, sign flags and special-case flags, clear a 6-bit counter, and go to CALC.
REQ-014 The unit SHALL ignore start in every state except IDLE; operands need not stay stable after the latch cycle.
REQ-015 CALC: each cycle SHALL perform one radix-2 step (shift-add for multiply, restoring subtract for divide) and increment the counter.
REQ-016 CALC SHALL go to DONE after exactly 32 steps, so DONE is reached 33 cycles after the start cycle.
REQ-017 Divide by zero SHALL bypass CALC and go directly from IDLE to DONE. Result: quotient 0xFFFFFFFF; remainder rs1 (signed and unsigned).
REQ-018 Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM) SHALL bypass CALC. Result: quotient 0x80000000; remainder 0.
REQ-019 DONE SHALL assert result_valid for one cycle, drive result, and go to IDLE unconditionally.
REQ-020 Multiply SHALL form a 64-bit product of the magnitudes, then negate it if the signs differ. Signedness: MULH both signed; MULHSU rs1 signed, rs2 unsigned; MULHU/MUL unsigned magnitudes.
REQ-021 MUL SHALL return product[31:0]; MULH, MULHSU and MULHU SHALL return product[63:32].
REQ-022 Quotient sign SHALL equal sign(rs1) XOR sign(rs2); remainder sign SHALL equal sign(rs1). Both SHALL use two's complement.
REQ-023 stall SHALL equal (state==IDLE & start & !flush) | (state==CALC).
REQ-024 stall SHALL be low in DONE so that ID/EX advances; the stale start held in DONE is therefore ignored.
REQ-025 Back-to-back RV32M ops SHALL be accepted: IDLE with a new start in the cycle after DONE.
REQ-026 flush in any state SHALL force IDLE at the next edge with result_valid=0. flush takes priority over start and over the CALC→DONE and DONE transitions.
REQ-027 result SHALL hold its last value outside DONE; it is not required to be zeroed.

Reset
REQ-028 rst SHALL asynchronously force state=IDLE, counter=0, result=0, result_valid=0 and all internal registers to 0.
REQ-029 stall SHALL be 0 during reset regardless of start.
REQ-030 Reset asserted mid-CALC SHALL discard the operation; after deassertion no result_valid pulse SHALL occur for that operation.

Structure
REQ-031 The FSM state enum and the eight RV32M funct3 constants SHALL live in shared package muldiv_pkg, alongside the existing ALU signal definitions.
REQ-032 The block SHALL be a single module with no sub-module; the counter, shift registers and sign fix-up are inline.
REQ-033 Datapath registers SHALL be: 64-bit accumulator/remainder-quotient register, 32-bit operand register, 6-bit counter, 2-bit state.

Verification
REQ-034 MUL: rs1=7, rs2=-3 → stall high 33 cycles; result=0xFFFFFFEB with result_valid in cycle 34.
REQ-035 MULH: rs1=0x80000000, rs2=0x80000000 → result 0x40000000. MULHU: rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → result 0xFFFFFFFE.
REQ-036 DIV: rs1=-7, rs2=2 → result 0xFFFFFFFD. REM with the same operands → result 0xFFFFFFFF.
REQ-037 DIVU: rs1=5, rs2=0 → result 0xFFFFFFFF two cycles after start. REM: rs1=0x80000000, rs2=-1 → result 0 with bypass timing.
REQ-038 flush asserted in CALC cycle 10 → IDLE next cycle, stall low, no result_valid. A following start (DIVU 100/7) → result 14 with normal timing.
REQ-039 rst pulsed mid-CALC → all outputs 0. Back-to-back MUL then DIVU → two result_valid pulses with exactly one IDLE cycle between them.
